// File: rtl/rx_comma_align.sv
// K28.5 word aligner: finds the comma at any of 10 bit offsets, barrel-shifts
// the deserialized stream onto symbol boundaries and tracks lock with hysteresis.
module rx_comma_align #(
  parameter logic [9:0]  COMMA_POS = 10'b0011111010,
  parameter logic [9:0]  COMMA_NEG = 10'b1100000101,
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned LOSS_CNT  = 4
) (
  input  logic       RXCLK,
  input  logic       RESET_L,
  input  logic [9:0] data_in,
  input  logic       valid_in,
  input  logic       en_align,
  output logic [9:0] data_out,
  output logic       valid_out,
  output logic       is_comma,
  output logic       sync,
  output logic [3:0] align_ofs,
  output logic       realign
);

  typedef enum logic [1:0] {
    ST_LOS  = 2'd0,
    ST_ACQ  = 2'd1,
    ST_SYNC = 2'd2
  } state_e;

  localparam logic [3:0] LOCK_W = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_W = 4'(LOSS_CNT);

  state_e     state_q, state_d;
  logic [3:0] lock_q, lock_d;
  logic [3:0] err_q, err_d;
  logic [3:0] ofs_q, ofs_d;
  logic       realign_q, realign_d;
  logic [9:0] prev_q;
  logic [9:0] dout_q;
  logic       vout_q;
  logic       comma_q;
  logic       sync_q, sync_d;

  logic [19:0] win;
  logic [9:0]  hit;
  logic [3:0]  hit_k;
  logic        any_hit;
  logic        hit_al;
  logic        hit_mis;
  logic [3:0]  lock_inc;
  logic [3:0]  err_inc;
  logic [9:0]  sel;
  logic        sel_comma;

  assign win = {data_in, prev_q};

  // Descending scan so the lowest hitting offset wins.
  always_comb begin
    hit   = '0;
    hit_k = '0;
    for (int k = 9; k >= 0; k--) begin
      hit[k] = (win[k +: 10] == COMMA_POS) ||
               (win[k +: 10] == COMMA_NEG);
      if (hit[k]) hit_k = 4'(k);
    end
  end

  assign any_hit  = |hit;
  assign hit_al   = |(hit & (10'b1 << ofs_q));
  assign hit_mis  = any_hit & ~hit_al;
  assign lock_inc = (lock_q == 4'hF) ? lock_q : lock_q + 4'd1;
  assign err_inc  = (err_q == 4'hF) ? err_q : err_q + 4'd1;

  always_ff @(posedge RXCLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q   <= ST_LOS;
      lock_q    <= '0;
      err_q     <= '0;
      ofs_q     <= '0;
      realign_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      err_q     <= err_d;
      ofs_q     <= ofs_d;
      realign_q <= realign_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    err_d     = err_q;
    ofs_d     = ofs_q;
    realign_d = 1'b0;
    if (valid_in) begin
      unique case (state_q)
        ST_LOS: begin
          if (hit_al) begin
            state_d = ST_ACQ;
            lock_d  = 4'd1;
          end else if (hit_mis && en_align) begin
            ofs_d     = hit_k;
            realign_d = 1'b1;
            state_d   = ST_ACQ;
            lock_d    = 4'd1;
          end
        end
        ST_ACQ: begin
          if (hit_al) begin
            lock_d = lock_inc;
            if (lock_inc >= LOCK_W) begin
              state_d = ST_SYNC;
              err_d   = '0;
            end
          end else if (hit_mis && en_align) begin
            ofs_d     = hit_k;
            realign_d = 1'b1;
            lock_d    = 4'd1;
          end
        end
        ST_SYNC: begin
          if (hit_al) begin
            err_d = '0;
          end else if (hit_mis) begin
            err_d = err_inc;
            if (err_inc >= LOSS_W) begin
              state_d = ST_LOS;
              lock_d  = '0;
              err_d   = '0;
            end
          end
        end
        default: state_d = ST_LOS;
      endcase
    end
  end

  // Select with the next offset so a realigning comma is already aligned.
  always_comb begin
    sel = win[9:0];
    for (int k = 0; k < 10; k++) begin
      if (ofs_d == 4'(k)) sel = win[k +: 10];
    end
    sel_comma = (sel == COMMA_POS) || (sel == COMMA_NEG);
    sync_d    = (state_d == ST_SYNC);
  end

  always_ff @(posedge RXCLK or negedge RESET_L) begin
    if (!RESET_L) begin
      prev_q  <= '0;
      dout_q  <= '0;
      vout_q  <= 1'b0;
      comma_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      vout_q <= valid_in;
      sync_q <= sync_d;
      if (valid_in) begin
        prev_q  <= data_in;
        dout_q  <= sel;
        comma_q <= sel_comma;
      end
    end
  end

  assign data_out  = dout_q;
  assign valid_out = vout_q;
  assign is_comma  = comma_q;
  assign sync      = sync_q;
  assign align_ofs = ofs_q;
  assign realign   = realign_q;

endmodule

// File: tb/tb_rx_comma_align.sv
// Bench for rx_comma_align: a bit-serial stream model with adjustable delay
// feeds the aligner; vectors and sequences check alignment and lock behaviour.
module tb_rx_comma_align;

  localparam logic [9:0] POS = 10'b0011111010;
  localparam logic [9:0] NEG = 10'b1100000101;
  localparam logic [9:0] F1  = 10'h2AA;
  localparam logic [9:0] F2  = 10'h155;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic       clk;
  logic       RESET_L;
  logic [9:0] data_in;
  logic       valid_in;
  logic       en_align;
  logic [9:0] data_out;
  logic       valid_out;
  logic       is_comma;
  logic       sync;
  logic [3:0] align_ofs;
  logic       realign;

  int n_chk = 0;
  int n_err = 0;

  rx_comma_align dut (
    .RXCLK     (clk),
    .RESET_L   (RESET_L),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .en_align  (en_align),
    .data_out  (data_out),
    .valid_out (valid_out),
    .is_comma  (is_comma),
    .sync      (sync),
    .align_ofs (align_ofs),
    .realign   (realign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic       v;
    logic       chk_d;
    logic [9:0] exp_d;
    logic       chk_k;
    logic       exp_k;
    logic       exp_vo;
    logic       exp_sync;
    logic [3:0] exp_ofs;
    logic       exp_re;
  } vec_t;

  vec_t tbl[$];
  logic fifo[$];
  int   gi;

  function automatic vec_t row(logic v, logic cd, logic [9:0] d,
                               logic ck, logic k, logic vo, logic sy,
                               logic [3:0] ofs, logic re);
    vec_t r;
    r.v = v; r.chk_d = cd; r.exp_d = d; r.chk_k = ck; r.exp_k = k;
    r.exp_vo = vo; r.exp_sync = sy; r.exp_ofs = ofs; r.exp_re = re;
    return r;
  endfunction

  // Transmitted symbol i: comma every 4th word, polarity alternating.
  function automatic logic [9:0] sym_at(int i);
    if (i % 4 == 2) return (((i / 4) % 2) != 0) ? NEG : POS;
    return ((i % 2) != 0) ? F2 : F1;
  endfunction

  task automatic chk_bit(string nm, int m, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s word %0d: got %b expected %b", nm, m, act, exp);
    end
  endtask

  task automatic chk_vec(string nm, int m, logic [9:0] act, logic [9:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s word %0d: got %h expected %h", nm, m, act, exp);
    end
  endtask

  task automatic chk_ofs(string nm, int m, logic [3:0] act, logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s word %0d: got %0d expected %0d", nm, m, act, exp);
    end
  endtask

  task automatic chk_ctl(string tag, int m, logic vo, logic sy,
                         logic [3:0] ofs, logic re);
    chk_bit({tag, " valid_out"}, m, valid_out, vo);
    chk_bit({tag, " sync"}, m, sync, sy);
    chk_ofs({tag, " align_ofs"}, m, align_ofs, ofs);
    chk_bit({tag, " realign"}, m, realign, re);
  endtask

  task automatic chk_zero(string tag);
    chk_vec({tag, " data_out"}, -1, data_out, 10'h000);
    chk_bit({tag, " is_comma"}, -1, is_comma, 1'b0);
    chk_ctl(tag, -1, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic step(input logic v, input logic en, input logic [9:0] d);
    @(negedge clk);
    valid_in = v;
    en_align = en;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push_sym(input logic [9:0] s);
    for (int b = 0; b < 10; b++) fifo.push_back(s[b]);
  endtask

  // Delay the serial stream by d bits, filling with the alternating pattern.
  task automatic start_stream(input int d);
    fifo.delete();
    gi = 0;
    for (int j = -d; j < 0; j++) fifo.push_back((j & 1) != 0);
  endtask

  task automatic slip(input int n);
    for (int j = 0; j < n; j++) fifo.push_back((j & 1) != 0);
  endtask

  task automatic feed(input logic en);
    logic [9:0] w;
    while (fifo.size() < 10) begin
      push_sym(sym_at(gi));
      gi++;
    end
    for (int b = 0; b < 10; b++) w[b] = fifo.pop_front();
    step(1'b1, en, w);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 RESET_L = 1'b0;
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    RESET_L = 1'b1;
  endtask

  initial begin
    RESET_L  = 1'b0;
    valid_in = 1'b0;
    en_align = 1'b0;
    data_in  = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    RESET_L = 1'b1;

    // Acquire at delay 3 with a 5-cycle gap in ACQ.
    tbl.push_back(row(Y, Y, 10'h000, Y, N, Y, N, 4'd0, N));
    tbl.push_back(row(Y, N, 10'h000, Y, N, Y, N, 4'd0, N));
    tbl.push_back(row(Y, N, 10'h000, Y, N, Y, N, 4'd0, N));
    tbl.push_back(row(Y, Y, POS,     Y, Y, Y, N, 4'd3, Y));
    tbl.push_back(row(Y, Y, F2,      Y, N, Y, N, 4'd3, N));
    tbl.push_back(row(Y, Y, F1,      Y, N, Y, N, 4'd3, N));
    tbl.push_back(row(Y, Y, F2,      Y, N, Y, N, 4'd3, N));
    tbl.push_back(row(Y, Y, NEG,     Y, Y, Y, N, 4'd3, N));
    for (int g = 0; g < 5; g++)
      tbl.push_back(row(N, Y, NEG, N, N, N, N, 4'd3, N));
    tbl.push_back(row(Y, Y, F2,      Y, N, Y, N, 4'd3, N));
    tbl.push_back(row(Y, Y, F1,      Y, N, Y, N, 4'd3, N));
    tbl.push_back(row(Y, Y, F2,      Y, N, Y, N, 4'd3, N));
    tbl.push_back(row(Y, Y, POS,     Y, Y, Y, N, 4'd3, N));
    tbl.push_back(row(Y, Y, F2,      Y, N, Y, N, 4'd3, N));
    tbl.push_back(row(Y, Y, F1,      Y, N, Y, N, 4'd3, N));
    tbl.push_back(row(Y, Y, F2,      Y, N, Y, N, 4'd3, N));
    tbl.push_back(row(Y, Y, NEG,     Y, Y, Y, Y, 4'd3, N));
    tbl.push_back(row(Y, Y, F2,      Y, N, Y, Y, 4'd3, N));

    start_stream(3);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].v) feed(1'b1);
      else step(1'b0, 1'b1, 10'h3FF);
      if (tbl[i].chk_d) chk_vec("acq data_out", i, data_out, tbl[i].exp_d);
      if (tbl[i].chk_k) chk_bit("acq is_comma", i, is_comma, tbl[i].exp_k);
      chk_ctl("acq", i, tbl[i].exp_vo, tbl[i].exp_sync,
              tbl[i].exp_ofs, tbl[i].exp_re);
    end

    // Slip the stream from offset 3 to 7 while in SYNC.
    slip(4);
    for (int m = 17; m <= 48; m++) begin
      feed(1'b1);
      chk_ctl("slip", m, 1'b1, (m < 31) || (m >= 47),
              (m < 35) ? 4'd3 : 4'd7, m == 35);
      if (m >= 35) begin
        chk_vec("slip data_out", m, data_out, sym_at(m - 1));
        chk_bit("slip is_comma", m, is_comma, ((m - 1) % 4) == 2);
      end
    end

    // Asynchronous reset while synced, checked before any clock edge.
    @(negedge clk);
    #2 RESET_L = 1'b0;
    valid_in = 1'b0;
    #1 chk_zero("async reset");
    repeat (2) @(negedge clk);
    RESET_L = 1'b1;

    // Offset 0, alternating polarity; first comma after reset starts lock.
    start_stream(0);
    for (int m = 0; m <= 16; m++) begin
      feed(1'b1);
      chk_vec("pol data_out", m, data_out,
              (m == 0) ? 10'h000 : sym_at(m - 1));
      chk_bit("pol is_comma", m, is_comma, (m > 0) && (((m - 1) % 4) == 2));
      chk_ctl("pol", m, 1'b1, m >= 15, 4'd0, 1'b0);
    end

    // Commas at offset 5 ignored until en_align rises.
    pulse_reset();
    start_stream(5);
    for (int m = 0; m <= 16; m++) begin
      feed(m >= 13);
      chk_ctl("en_align", m, 1'b1, 1'b0, (m < 15) ? 4'd0 : 4'd5, m == 15);
      if (m >= 15) begin
        chk_vec("en_align data_out", m, data_out, sym_at(m - 1));
        chk_bit("en_align is_comma", m, is_comma, m == 15);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
